// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  serial_data_out,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  par_q;
  logic                  par_en_q;
  logic                  line_d;
  logic                  busy_d;
  logic                  stop_last;
  logic                  accept;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_q;
  logic stop_d;

  assign stop_last = stop_q;
`else
  assign stop_last = 1'b1;
`endif

  assign accept = data_valid &&
                  ((state_q == IDLE) ||
                   ((state_q == STOP) && stop_last));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    line_d  = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
    stop_d  = stop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          line_d  = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        line_d  = shift_q[0];
      end
      DATA: begin
        if (cnt_q == LAST) begin
`ifdef UART_TX_TWO_STOP_EN
          stop_d = 1'b0;
`endif
          if (par_en_q) begin
            state_d = PARITY;
            line_d  = par_q;
          end else begin
            state_d = STOP;
            line_d  = 1'b1;
          end
        end else begin
          // shift_q[0] is on the line now; bit 1 goes next
          cnt_d   = cnt_q + 1'b1;
          shift_d = shift_q >> 1;
          line_d  = shift_q[1];
        end
      end
      PARITY: begin
        state_d = STOP;
        line_d  = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        stop_d  = 1'b0;
`endif
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_q) begin
          stop_d  = 1'b1;
          line_d  = 1'b1;
        end else
`endif
        if (accept) begin
          state_d = START;
          line_d  = 1'b0;
        end else begin
          state_d = IDLE;
          line_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      shift_q         <= '0;
      par_q           <= 1'b0;
      par_en_q        <= 1'b0;
      serial_data_out <= 1'b1;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      serial_data_out <= line_d;
      busy            <= busy_d;
      if (accept) begin
        shift_q  <= parallel_data;
        par_q    <= (^parallel_data) ^ parity_type;
        par_en_q <= parity_enable;
      end else begin
        shift_q  <= shift_d;
      end
    end
  end

`ifdef UART_TX_TWO_STOP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit path: the transmit-side counterpart of the receiver's oversampling data sampler.
- Accepts a parallel byte with a valid strobe and serialises it onto the TX line as: start bit, data bits LSB first, optional parity bit, stop bit.
- Runs on the baud-rate clock, one bit per clk cycle, so it needs no prescale counter.
- Sits between the system-side TX FIFO/controller and the serial_data_out pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (valid range 5..9).

Ports:
- clk  input  1  baud-rate clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on rising clk.
- parallel_data  input  DATA_WIDTH  byte to transmit; sampled on the accept edge.
- data_valid  input  1  request to send parallel_data.
- parity_enable  input  1  1 = insert parity bit; sampled on the accept edge.
- parity_type  input  1  0 = even, 1 = odd; sampled on the accept edge.
- serial_data_out  output  1  registered TX line; idles high.
- busy  output  1  registered; high while a frame is on the line.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, serial_data_out=1, busy=0, bit counter=0, shift/parity registers=0.
  - Applies from any state; a frame in progress is abandoned and the line is high from that edge on.
  - No partial stop bit is emitted.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered, so each state's line value appears in the cycle the state is occupied.
- Accept condition: data_valid==1 while state is IDLE, or while state is STOP (back-to-back frames). On the accept edge:
  - Latch parallel_data, parity_enable and parity_type.
  - Compute parity_bit = (^parallel_data) XOR parity_type.
  - Go to START.
  - data_valid at any other time is ignored. No error is flagged.
- IDLE: serial_data_out=1, busy=0.
- START: serial_data_out=0, busy=1. Next state is DATA with counter=0.
- DATA: serial_data_out = latched data bit[counter]; counter increments each cycle.
  - When counter==DATA_WIDTH-1, next state is PARITY if latched parity_enable, else STOP.
  - Counter width is $clog2(DATA_WIDTH). The counter never wraps within a frame.
- PARITY: serial_data_out=parity_bit, busy=1. Next state is STOP.
- STOP: serial_data_out=1, busy=1 for one cycle (two cycles with the optional feature).
  - Next state is START if the accept condition holds, else IDLE; busy falls on the IDLE transition.
- Frame length: 2+DATA_WIDTH cycles without parity, 3+DATA_WIDTH with parity. Back-to-back frames have no idle gap.
- Latency: first start-bit cycle begins at the rising edge that samples data_valid=1 in IDLE, i.e. one cycle after data_valid is presented.
- Input changes to parallel_data and parity controls mid-frame have no effect on the frame being sent.
- busy is a pure function of state (busy = state!=IDLE), registered alongside serial_data_out so both change on the same edge.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined:
  - STOP lasts two cycles, tracked by a 1-bit stop counter; the accept condition applies only in the second stop cycle.
  - Frame length increases by 1.
- Undefined:
  - Exactly one stop cycle; the stop counter logic is absent.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, data_valid=0 for 5 cycles -> serial_data_out=1, busy=0 throughout.
- Even parity frame: parallel_data=8'hA5, parity_enable=1, parity_type=0, one-cycle data_valid -> line sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity=0, stop); busy high for exactly 11 cycles, then 0.
- Odd parity / no parity: 8'hA5 with parity_type=1 -> parity bit=1. 8'h0F with parity_enable=0 -> 0,1,1,1,1,0,0,0,0,1 and busy high for 10 cycles.
- Back-to-back: data_valid held high with 8'h55 then 8'hAA, parity off -> second start bit immediately follows first stop bit (no idle cycle); data_valid during DATA ignored; parallel_data changed mid-frame does not corrupt bits.
- Reset mid-frame: assert reset=0 during data bit 3 of 8'h00 -> line=1, busy=0 after that edge; next data_valid=1 with 8'hFF yields a complete, correct frame.
- UART_TX_TWO_STOP_EN defined: 8'h3C, parity off -> 11-cycle frame ending in two 1s; data_valid in first stop cycle deferred to second stop cycle.
